alu_wide_sequencer: RTL and testbench

Two-pass sequencer that performs 2×WIDTH-bit operations on a single WIDTH-bit ALU instance. It accepts one double-width request over a valid/ready handshake and runs the low half, then the high half, chaining carry through the ALU carry-in. It returns the double-width result with NZCV flags over a second valid/ready handshake. It sits between the execute-stage control and the shared ALU, and issues 64-bit arithmetic at WIDTH=32.

---
 rtl/alu_pkg.sv | 45 ++++
 rtl/alu_wide_sequencer_alu.sv | 62 ++++++
 rtl/alu_wide_sequencer.sv | 124 ++++++++++++
 tb/tb_alu_wide_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared op-codes, sequencer state encoding and the double-width pass mapping
// for the two-pass wide ALU sequencer.
package alu_pkg;

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpRsb = 4'b0011;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpAdc = 4'b0101;
  localparam logic [3:0] OpSbc = 4'b0110;
  localparam logic [3:0] OpRsc = 4'b0111;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpBic = 4'b1110;
  localparam logic [3:0] OpMvn = 4'b1111;

  typedef enum logic [1:0] {StIdle, StLo, StHi, StDone} state_e;

  typedef struct packed {
    logic [3:0] lo_op;
    logic [3:0] hi_op;
    logic       lo_ci_req;  // low pass takes the request carry-in
  } pass_t;

  function automatic pass_t pass_map(input logic [3:0] op);
    pass_t p;
    p.lo_op     = op;
    p.hi_op     = op;
    p.lo_ci_req = 1'b0;
    case (op)
      OpAdd:               p.hi_op = OpAdc;
      OpSub:               p.hi_op = OpSbc;
      OpRsb:               p.hi_op = OpRsc;
      OpAdc, OpSbc, OpRsc: p.lo_ci_req = 1'b1;
      default:             ;
    endcase
    return p;
  endfunction

  function automatic logic op_illegal(input logic [3:0] op);
    return op[3:2] == 2'b10;
  endfunction

endpackage

// File: rtl/alu_wide_sequencer_alu.sv
// Single-width combinational ALU; subtract carry-out means "no borrow".
module alu_wide_sequencer_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic             ci,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             ovf,
  output logic             n,
  output logic             z
);

  logic [WIDTH-1:0] x, y;
  logic             cin;
  logic             arith;
  logic [WIDTH:0]   sum;

  always_comb begin
    x     = a;
    y     = b;
    cin   = 1'b0;
    arith = 1'b1;
    case (op)
      OpAdd:   ;
      OpAdc:   cin = ci;
      OpSub:   begin y = ~b; cin = 1'b1; end
      OpSbc:   begin y = ~b; cin = ci;   end
      OpRsb:   begin x = b; y = ~a; cin = 1'b1; end
      OpRsc:   begin x = b; y = ~a; cin = ci;   end
      default: arith = 1'b0;
    endcase

    sum    = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    result = '0;
    co     = 1'b0;
    ovf    = 1'b0;
    if (arith) begin
      result = sum[WIDTH-1:0];
      co     = sum[WIDTH];
      ovf    = (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
    end else begin
      case (op)
        OpAnd:   result = a & b;
        OpEor:   result = a ^ b;
        OpOrr:   result = a | b;
        OpMov:   result = b;
        OpBic:   result = a & ~b;
        OpMvn:   result = ~b;
        default: result = '0;
      endcase
    end
  end

  assign n = result[WIDTH-1];
  assign z = ~|result;

endmodule

// File: rtl/alu_wide_sequencer.sv
// Runs a 2*WIDTH-bit op as a low pass then a high pass on one WIDTH-bit ALU,
// chaining the low-pass carry into the high pass.
module alu_wide_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [3:0]         req_op,
  input  logic               req_ci,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_n,
  output logic               rsp_z,
  output logic               rsp_c,
  output logic               rsp_v,
  output logic               rsp_err
);

  state_e             state_q;
  logic [3:0]         op_q;
  logic               ci_q;
  logic [2*WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0]   lo_result_q;
  logic               lo_co_q;

  pass_t            pass;
  logic [3:0]       alu_op;
  logic             alu_ci;
  logic [WIDTH-1:0] alu_a, alu_b, alu_result;
  logic             alu_co, alu_ovf;
  logic             unused_alu_n, unused_alu_z;

  assign pass      = pass_map(op_q);
  assign req_ready = (state_q == StIdle);

  always_comb begin
    if (state_q == StHi) begin
      alu_op = pass.hi_op;
      alu_ci = lo_co_q;
      alu_a  = a_q[2*WIDTH-1:WIDTH];
      alu_b  = b_q[2*WIDTH-1:WIDTH];
    end else begin
      alu_op = pass.lo_op;
      alu_ci = pass.lo_ci_req & ci_q;
      alu_a  = a_q[WIDTH-1:0];
      alu_b  = b_q[WIDTH-1:0];
    end
  end

  alu_wide_sequencer_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op     (alu_op),
    .ci     (alu_ci),
    .a      (alu_a),
    .b      (alu_b),
    .result (alu_result),
    .co     (alu_co),
    .ovf    (alu_ovf),
    .n      (unused_alu_n),
    .z      (unused_alu_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      ci_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      lo_result_q <= '0;
      lo_co_q     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_n       <= 1'b0;
      rsp_z       <= 1'b0;
      rsp_c       <= 1'b0;
      rsp_v       <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q    <= req_op;
            ci_q    <= req_ci;
            a_q     <= req_a;
            b_q     <= req_b;
            state_q <= StLo;
          end
        end
        StLo: begin
          lo_result_q <= alu_result;
          lo_co_q     <= alu_co;
          state_q     <= StHi;
        end
        StHi: begin
          rsp_result <= {alu_result, lo_result_q};
          rsp_n      <= alu_result[WIDTH-1];
          rsp_z      <= (alu_result == '0) && (lo_result_q == '0);
          rsp_c      <= alu_co;
          rsp_v      <= alu_ovf;
          rsp_err    <= op_illegal(op_q);
          rsp_valid  <= 1'b1;
          state_q    <= StDone;
        end
        StDone: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_wide_sequencer.sv
// Self-checking bench for alu_wide_sequencer at WIDTH=32 against a 64-bit arithmetic model.
module tb_alu_wide_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_ci;
  logic [3:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [63:0] rsp_result;
  logic        rsp_n, rsp_z, rsp_c, rsp_v, rsp_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  alu_wide_sequencer #(
    .WIDTH (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_ci     (req_ci),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_n      (rsp_n),
    .rsp_z      (rsp_z),
    .rsp_c      (rsp_c),
    .rsp_v      (rsp_v),
    .rsp_err    (rsp_err)
  );

  // Whole-operation model: flags packed as {n, z, c, v, err}.
  function automatic void model(input logic [3:0] op, input logic ci, input logic [63:0] a,
                                input logic [63:0] b, output logic [63:0] r,
                                output logic [4:0] f);
    logic [65:0] u, s;
    logic [63:0] p, q;
    logic        c, v, err, bw;
    c = 1'b0; v = 1'b0; err = 1'b0; r = '0;
    case (op)
      4'h4, 4'h5: begin
        u = {2'b00, a} + {2'b00, b} + 66'(op == 4'h5 ? ci : 1'b0);
        s = {{2{a[63]}}, a} + {{2{b[63]}}, b} + 66'(op == 4'h5 ? ci : 1'b0);
        r = u[63:0]; c = u[64]; v = s[64] != s[63];
      end
      4'h2, 4'h3, 4'h6, 4'h7: begin
        p  = op[0] ? b : a;
        q  = op[0] ? a : b;
        bw = op[2] ? ~ci : 1'b0;
        u  = {2'b00, p} - {2'b00, q} - 66'(bw);
        s  = {{2{p[63]}}, p} - {{2{q[63]}}, q} - 66'(bw);
        r  = u[63:0]; c = ~u[65]; v = s[64] != s[63];
      end
      4'h0: r = a & b;
      4'h1: r = a ^ b;
      4'hc: r = a | b;
      4'hd: r = b;
      4'he: r = a & ~b;
      4'hf: r = ~b;
      default: err = 1'b1;
    endcase
    f = {r[63], r == 64'd0, c, v, err};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0:       return 64'd0;
      1:       return {64{1'b1}};
      2:       return {1'b0, {63{1'b1}}};
      3:       return {32'($urandom_range(0, 1)), 32'hFFFF_FFFF};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // Transaction helpers: stimulus only, comparisons stay in the test tasks.
  task automatic send_req(input logic [3:0] op, input logic ci, input logic [63:0] a,
                          input logic [63:0] b, output bit ok);
    int k = 0;
    @(negedge clk);
    while (!req_ready && k < 20) begin @(negedge clk); k++; end
    ok = req_ready;
    req_valid = 1'b1; req_op = op; req_ci = ci; req_a = a; req_b = b;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_op = 4'($urandom); req_ci = 1'($urandom); req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
  endtask

  task automatic wait_rsp(output int lat);
    int cyc;
    @(negedge clk);
    cyc = 1;
    while (!rsp_valid && cyc < 20) begin @(negedge clk); cyc++; end
    lat = rsp_valid ? cyc : -1;
  endtask

  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic ci,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_r, input logic [4:0] exp_f);
    bit ok; int lat;
    send_req(op, ci, a, b, ok);
    wait_rsp(lat);
    vectors++;
    if (!ok || lat !== 3) begin
      miscompares++;
      $display("FAIL %s latency: got %0d accepted %0d, want 3", name, lat, ok);
    end
    vectors++;
    if ({rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err} !== {exp_r, exp_f}) begin
      miscompares++;
      $display("FAIL %s: got %h nzcve=%b, want %h nzcve=%b", name, rsp_result,
               {rsp_n, rsp_z, rsp_c, rsp_v, rsp_err}, exp_r, exp_f);
    end
    take_rsp();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_ci = 1'b0; req_a = '0; req_b = '0;
    #3;
    vectors++;
    if ({req_ready, rsp_valid, rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err} !==
        {1'b1, 1'b0, 64'd0, 5'b0}) begin
      miscompares++;
      $display("FAIL reset: got ready=%b valid=%b res=%h flags=%b, want 1 0 0 0", req_ready,
               rsp_valid, rsp_result, {rsp_n, rsp_z, rsp_c, rsp_v, rsp_err});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    directed("add_carry_chain", 4'h4, 1'b0, 64'h0000_0000_FFFF_FFFF, 64'd1,
             64'h0000_0001_0000_0000, 5'b00000);
    directed("sub_borrow", 4'h2, 1'b1, 64'd0, 64'd1, {64{1'b1}}, 5'b10000);
    directed("sub_equal", 4'h2, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
             64'd0, 5'b01100);
    directed("add_overflow", 4'h4, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
             64'h8000_0000_0000_0000, 5'b10010);
    directed("adc_ones", 4'h5, 1'b1, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}, 5'b10100);
  endtask

  task automatic test_illegal();
    directed("illegal_1000", 4'h8, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
             64'd0, 5'b01001);
    directed("orr_after_illegal", 4'hc, 1'b0, 64'hF0F0_F0F0_F0F0_F0F0,
             64'h0F0F_0F0F_0F0F_0F0F, {64{1'b1}}, 5'b10000);
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    logic [63:0] held;
    send_req(4'h4, 1'b0, 64'h1111_2222_3333_4444, 64'h0101_0101_0101_0101, ok);
    wait_rsp(lat);
    held = rsp_result;
    vectors++;
    if (!ok || lat !== 3 || held !== 64'h1212_2323_3434_4545) begin
      miscompares++;
      $display("FAIL bp_first: got %h lat %0d, want 1212232334344545 lat 3", held, lat);
    end
    for (int i = 0; i < 10; i++) begin
      req_valid = 1'($urandom); req_op = 4'($urandom); req_a = {$urandom, $urandom};
      @(negedge clk);
      vectors++;
      if ({rsp_valid, req_ready, rsp_result} !== {1'b1, 1'b0, held}) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got valid=%b ready=%b res=%h, want 1 0 %h", i, rsp_valid,
                 req_ready, rsp_result, held);
      end
    end
    req_valid = 1'b0;
    take_rsp();
    @(negedge clk);
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL bp_release: got valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
    directed("bp_next", 4'h3, 1'b0, 64'd5, 64'd7, 64'd2, 5'b00100);
  endtask

  task automatic test_reset_midflight();
    bit ok;
    send_req(4'h4, 1'b0, 64'hAAAA, 64'h5555, ok);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL reset_in_hi: got valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL stale_rsp[%0d]: got valid=%b, want 0", i, rsp_valid);
      end
    end
    directed("add_after_reset", 4'h4, 1'b0, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000,
             64'h0000_0001_0000_0000, 5'b00000);
  endtask

  task automatic test_random();
    bit ok; int lat;
    logic [3:0] op; logic ci; logic [63:0] a, b, er; logic [4:0] ef;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom); ci = 1'($urandom); a = pick(); b = pick();
      model(op, ci, a, b, er, ef);
      send_req(op, ci, a, b, ok);
      wait_rsp(lat);
      vectors++;
      if (!ok || lat !== 3 ||
          {rsp_result, rsp_n, rsp_z, rsp_c, rsp_v, rsp_err} !== {er, ef}) begin
        miscompares++;
        $display("FAIL rand[%0d] op=%h ci=%b a=%h b=%h: got %h nzcve=%b lat %0d, want %h %b lat 3",
                 i, op, ci, a, b, rsp_result, {rsp_n, rsp_z, rsp_c, rsp_v, rsp_err}, lat, er, ef);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      take_rsp();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_arith();
    test_illegal();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
